// File: rtl/axis_conv_pkg.sv
// Shared types and sizing helpers for the AXI-Stream convolution front/back end.
// Contents:
//   out_state_e - output serialiser FSM states
//   words_in    - S_AXIS words per packed ifmap vector
//   words_out   - M_AXIS words per psum vector
//   cnt_width   - counter width able to index n items (at least 1 bit)
package axis_conv_pkg;

  typedef enum logic [0:0] {StIdle, StSend} out_state_e;

  function automatic int unsigned words_in(input int unsigned mac_num,
                                           input int unsigned data_w,
                                           input int unsigned tdata_w);
    return (mac_num * data_w) / tdata_w;
  endfunction

  function automatic int unsigned words_out(input int unsigned mac_num,
                                            input int unsigned psum_w,
                                            input int unsigned tdata_w);
    return (mac_num * psum_w) / tdata_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pingpong_packer.sv
// Packs S_AXIS words into MAC_NUM-lane ifmap vectors held in two ping-pong buffers.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_tdata/s_tlast   - input word and early end-of-vector marker
//   s_tvalid/s_tready - input handshake; ready while the write buffer is not full
//   vec_out           - packed vector of the read buffer (zero when empty)
//   vec_last          - vector was closed by TLAST
//   vec_valid/vec_ready - output handshake; a taken buffer is cleared to zero
module axis_pingpong_packer
  import axis_conv_pkg::*;
#(
  parameter int unsigned MAC_NUM              = 256,
  parameter int unsigned DATA_W               = 5,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_tdata,
  input  logic                              s_tlast,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  output logic [MAC_NUM*DATA_W-1:0]         vec_out,
  output logic                              vec_last,
  output logic                              vec_valid,
  input  logic                              vec_ready
);

  localparam int unsigned VecW  = MAC_NUM * DATA_W;
  localparam int unsigned TW    = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned Words = words_in(MAC_NUM, DATA_W, C_S_AXIS_TDATA_WIDTH);
  localparam int unsigned CntW  = cnt_width(Words);

  logic [VecW-1:0] vbuf_q [2];
  logic [1:0]      full_q;
  logic [1:0]      last_q;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [CntW-1:0] wcnt_q;

  logic wr_fire;
  logic rd_fire;
  logic word_final;

  assign s_tready   = !rst && !full_q[wr_ptr_q];
  assign vec_valid  = !rst && full_q[rd_ptr_q];
  assign vec_out    = rst ? '0 : vbuf_q[rd_ptr_q];
  assign vec_last   = !rst && last_q[rd_ptr_q];

  assign wr_fire    = s_tvalid && s_tready;
  assign rd_fire    = vec_valid && vec_ready;
  assign word_final = s_tlast || (wcnt_q == CntW'(Words - 1));

  // A write needs !full[wr] and a read needs full[rd], so when both fire they
  // always address different buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vbuf_q[0] <= '0;
      vbuf_q[1] <= '0;
      full_q    <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      if (rd_fire) begin
        vbuf_q[rd_ptr_q] <= '0;
        full_q[rd_ptr_q] <= 1'b0;
        last_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= !rd_ptr_q;
      end
      if (wr_fire) begin
        for (int k = 0; k < Words; k++) begin
          if (wcnt_q == CntW'(k)) begin
            vbuf_q[wr_ptr_q][k*TW +: TW] <= s_tdata;
          end
        end
        if (word_final) begin
          full_q[wr_ptr_q] <= 1'b1;
          last_q[wr_ptr_q] <= s_tlast;
          wr_ptr_q         <= !wr_ptr_q;
          wcnt_q           <= '0;
        end else begin
          wcnt_q <= wcnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axis_conv_io.sv
// AXI-Stream front/back end for the convolution datapath.
// Input side: S_AXIS words packed into ping-pong ifmap vectors (axis_pingpong_packer).
// Output side: psum vectors serialised onto M_AXIS with frame-aligned TLAST.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   S_AXIS_*                        - ifmap input stream (TSTRB ignored)
//   ifmaps_out/last/valid/ready     - packed ifmap vector to the MAC array
//   psum_in/psum_valid/psum_ready   - psum vector from the MAC array
//   frame_vectors                   - psum vectors per output frame (0 acts as 1)
//   M_AXIS_*                        - psum output stream (TKEEP all ones)
// Build option: define PSUM_RELU_EN to zero negative psum lanes at capture.
module axis_conv_io
  import axis_conv_pkg::*;
#(
  parameter int unsigned MAC_NUM              = 256,
  parameter int unsigned DATA_W               = 5,
  parameter int unsigned PSUM_W               = 5,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FRAME_W              = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [MAC_NUM*DATA_W-1:0]         ifmaps_out,
  output logic                              ifmaps_last,
  output logic                              ifmaps_valid,
  input  logic                              ifmaps_ready,
  input  logic [MAC_NUM*PSUM_W-1:0]         psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [FRAME_W-1:0]                frame_vectors,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned PVecW  = MAC_NUM * PSUM_W;
  localparam int unsigned MW     = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned WOut   = words_out(MAC_NUM, PSUM_W, C_M_AXIS_TDATA_WIDTH);
  localparam int unsigned OCntW  = cnt_width(WOut);

  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  axis_pingpong_packer #(
    .MAC_NUM              (MAC_NUM),
    .DATA_W               (DATA_W),
    .C_S_AXIS_TDATA_WIDTH (C_S_AXIS_TDATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (S_AXIS_TDATA),
    .s_tlast   (S_AXIS_TLAST),
    .s_tvalid  (S_AXIS_TVALID),
    .s_tready  (S_AXIS_TREADY),
    .vec_out   (ifmaps_out),
    .vec_last  (ifmaps_last),
    .vec_valid (ifmaps_valid),
    .vec_ready (ifmaps_ready)
  );

  // ---------------------------------------------------------------------------
  // Psum serialiser
  // ---------------------------------------------------------------------------
  out_state_e         state_q, state_d;
  logic [PVecW-1:0]   shreg_q;
  logic [OCntW-1:0]   widx_q;
  logic [FRAME_W-1:0] fcnt_q;
  logic [FRAME_W-1:0] flen_q;
  logic [PVecW-1:0]   cap_vec;

  logic capture;
  logic word_fire;
  logic word_last;
  logic frame_last;

  assign capture    = (state_q == StIdle) && psum_valid;
  assign word_fire  = (state_q == StSend) && M_AXIS_TREADY;
  assign word_last  = (widx_q == OCntW'(WOut - 1));
  assign frame_last = (fcnt_q == flen_q - FRAME_W'(1));

  always_comb begin
    cap_vec = psum_in;
`ifdef PSUM_RELU_EN
    for (int i = 0; i < MAC_NUM; i++) begin
      if (psum_in[i*PSUM_W + PSUM_W - 1]) begin
        cap_vec[i*PSUM_W +: PSUM_W] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (psum_valid) state_d = StSend;
      StSend:  if (M_AXIS_TREADY && word_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    psum_ready    = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: psum_ready = 1'b1;
        StSend: begin
          M_AXIS_TVALID = 1'b1;
          M_AXIS_TLAST  = word_last && frame_last;
          M_AXIS_TDATA  = shreg_q[MW-1:0];
        end
        default: ;
      endcase
    end
  end

  // The low word of the shift register is always word widx of the vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      widx_q  <= '0;
      fcnt_q  <= '0;
      flen_q  <= FRAME_W'(1);
    end else if (capture) begin
      shreg_q <= cap_vec;
      widx_q  <= '0;
      if (fcnt_q == '0) begin
        flen_q <= (frame_vectors == '0) ? FRAME_W'(1) : frame_vectors;
      end
    end else if (word_fire) begin
      shreg_q <= shreg_q >> MW;
      if (word_last) begin
        widx_q <= '0;
        fcnt_q <= frame_last ? '0 : fcnt_q + FRAME_W'(1);
      end else begin
        widx_q <= widx_q + OCntW'(1);
      end
    end
  end

  assign M_AXIS_TKEEP = '1;

endmodule

// File: tb/tb_axis_conv_io.sv
module tb_axis_conv_io;

  localparam int MAC_NUM = 256;
  localparam int DATA_W  = 5;
  localparam int PSUM_W  = 5;
  localparam int SW      = 32;
  localparam int MW      = 32;
  localparam int FRAME_W = 16;
  localparam int VIN     = MAC_NUM * DATA_W;
  localparam int VOUT    = MAC_NUM * PSUM_W;
  localparam int WIN     = VIN / SW;
  localparam int WOUT    = VOUT / MW;
  localparam int TMO     = 3000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [SW-1:0]      S_AXIS_TDATA = '0;
  logic [SW/8-1:0]    S_AXIS_TSTRB = '1;
  logic               S_AXIS_TLAST = 1'b0;
  logic               S_AXIS_TVALID = 1'b0;
  logic               S_AXIS_TREADY;
  logic [VIN-1:0]     ifmaps_out;
  logic               ifmaps_last;
  logic               ifmaps_valid;
  logic               ifmaps_ready = 1'b0;
  logic [VOUT-1:0]    psum_in = '0;
  logic               psum_valid = 1'b0;
  logic               psum_ready;
  logic [FRAME_W-1:0] frame_vectors = 16'd1;
  logic [MW-1:0]      M_AXIS_TDATA;
  logic [MW/8-1:0]    M_AXIS_TKEEP;
  logic               M_AXIS_TLAST;
  logic               M_AXIS_TVALID;
  logic               M_AXIS_TREADY = 1'b0;

  axis_conv_io dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .ifmaps_out    (ifmaps_out),
    .ifmaps_last   (ifmaps_last),
    .ifmaps_valid  (ifmaps_valid),
    .ifmaps_ready  (ifmaps_ready),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .frame_vectors (frame_vectors),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  always #5 clk = !clk;

  int total = 0;
  int bad   = 0;

  // Ready modes: 0 low, 1 high, 2 random per cycle.
  int rmode = 0;
  int tmode = 0;

  // Input-side reference: vectors assembled from accepted words.
  logic [VIN-1:0] in_cur = '0;
  int             in_k = 0;
  int             acc_count = 0;
  logic [VIN-1:0] exp_vec_q[$];
  logic           exp_vlast_q[$];

  // Output-side reference.
  logic [MW-1:0]  exp_word_q[$];
  logic           exp_wlast_q[$];
  int             fpos = 0;
  int             flen = 1;
  int             tlast_seen = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic check_vec(input string nm, input logic [VIN-1:0] act,
                           input logic [VIN-1:0] req);
    logic [SW-1:0] aw;
    logic [SW-1:0] rw;
    total++;
    if (act !== req) begin
      bad++;
      for (int k = 0; k < WIN; k++) begin
        aw = act[k*SW +: SW];
        rw = req[k*SW +: SW];
        if (aw !== rw) begin
          $display("FAIL %s word %0d: got %h want %h", nm, k, aw, rw);
          break;
        end
      end
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(posedge clk) begin
    #2;
    ifmaps_ready  = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    M_AXIS_TREADY = (tmode == 2) ? 1'($urandom_range(0, 1)) : (tmode == 1);
  end

  // Input monitor.
  always @(negedge clk) begin
    if (!rst && ifmaps_valid && ifmaps_ready) begin
      if (exp_vec_q.size() == 0) begin
        timeout_fail("ifmap vector with empty scoreboard");
      end else begin
        check_vec("ifmaps_out", ifmaps_out, exp_vec_q.pop_front());
        check("ifmaps_last", 64'(ifmaps_last), 64'(exp_vlast_q.pop_front()));
      end
    end
  end

  // Output monitor with stall-stability check.
  logic          prev_stall = 1'b0;
  logic [MW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("tvalid held", 64'(M_AXIS_TVALID), 64'd1);
        check("tdata held", 64'(M_AXIS_TDATA), 64'(prev_data));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (M_AXIS_TLAST) tlast_seen++;
        if (exp_word_q.size() == 0) begin
          timeout_fail("psum word with empty scoreboard");
        end else begin
          check("m_tdata", 64'(M_AXIS_TDATA), 64'(exp_word_q.pop_front()));
          check("m_tlast", 64'(M_AXIS_TLAST), 64'(exp_wlast_q.pop_front()));
        end
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
    end
  end

  task automatic send_word(input logic [SW-1:0] d, input logic l);
    int  n = 0;
    bit  ok = 1'b0;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    while (n < TMO) begin
      @(negedge clk);
      if (S_AXIS_TREADY) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (ok) begin
      in_cur[in_k*SW +: SW] = d;
      acc_count++;
      if (l || in_k == WIN - 1) begin
        exp_vec_q.push_back(in_cur);
        exp_vlast_q.push_back(l);
        in_cur = '0;
        in_k   = 0;
      end else begin
        in_k++;
      end
    end else begin
      timeout_fail("s_axis word accept");
    end
    @(posedge clk);
    #1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic send_psum(input logic [VOUT-1:0] v);
    int             n = 0;
    bit             ok = 1'b0;
    logic [VOUT-1:0] e;
    logic [PSUM_W-1:0] lane;
    psum_in    = v;
    psum_valid = 1'b1;
    while (n < TMO) begin
      @(negedge clk);
      if (psum_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (ok) begin
      e = v;
`ifdef PSUM_RELU_EN
      for (int i = 0; i < MAC_NUM; i++) begin
        lane = v[i*PSUM_W +: PSUM_W];
        if ($signed(lane) < 0) e[i*PSUM_W +: PSUM_W] = '0;
      end
`else
      lane = '0;
`endif
      if (fpos == 0) flen = (frame_vectors == 0) ? 1 : int'(frame_vectors);
      for (int w = 0; w < WOUT; w++) begin
        exp_word_q.push_back(e[w*MW +: MW]);
        exp_wlast_q.push_back((w == WOUT - 1) && (fpos == flen - 1));
      end
      fpos = (fpos == flen - 1) ? 0 : fpos + 1;
    end else begin
      timeout_fail("psum capture");
    end
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
  endtask

  function automatic logic [VOUT-1:0] rand_vec();
    logic [VOUT-1:0] v;
    for (int w = 0; w < WOUT; w++) v[w*MW +: MW] = $urandom;
    return v;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_vec_q.size() != 0 || exp_word_q.size() != 0 || M_AXIS_TVALID) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout_fail(nm);
  endtask

  initial begin
    logic [VOUT-1:0] rv;
    int base;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset s_tready", 64'(S_AXIS_TREADY), 64'd0);
    check("reset ifmaps_valid", 64'(ifmaps_valid), 64'd0);
    check("reset ifmaps_out", 64'(ifmaps_out[63:0]), 64'd0);
    check("reset ifmaps_last", 64'(ifmaps_last), 64'd0);
    check("reset psum_ready", 64'(psum_ready), 64'd0);
    check("reset m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    check("reset m_tdata", 64'(M_AXIS_TDATA), 64'd0);
    check("reset m_tlast", 64'(M_AXIS_TLAST), 64'd0);
    check("reset m_tkeep", 64'(M_AXIS_TKEEP), 64'hf);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset s_tready", 64'(S_AXIS_TREADY), 64'd1);
    check("post-reset psum_ready", 64'(psum_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full vector of counting words, consumer always ready.
    rmode = 1;
    for (int i = 1; i <= WIN; i++) begin
      if (i == WIN) begin
        send_word(SW'(i), 1'b0);
        @(negedge clk);
        check("vec latency valid", 64'(ifmaps_valid), 64'd1);
        check("vec word0", 64'(ifmaps_out[31:0]), 64'd1);
        check("vec word39", 64'(ifmaps_out[1279:1248]), 64'h28);
        check("vec last", 64'(ifmaps_last), 64'd0);
        @(posedge clk);
        #1;
      end else begin
        send_word(SW'(i), 1'b0);
      end
    end

    // Early TLAST on word 10.
    for (int i = 1; i <= 10; i++) send_word(SW'(32'h100 + i), i == 10);
    drain("drain early tlast");

    // Both buffers full with the consumer stalled.
    @(posedge clk);
    #1 rmode = 0;
    base = acc_count;
    fork
      begin
        for (int i = 0; i < 3 * WIN; i++) send_word($urandom, 1'b0);
      end
      begin
        n = 0;
        while (acc_count < base + 2 * WIN && n < TMO) begin
          @(negedge clk);
          n++;
        end
        if (n >= TMO) timeout_fail("fill two buffers");
        @(posedge clk);
        #1;
        @(negedge clk);
        check("both full tready", 64'(S_AXIS_TREADY), 64'd0);
        check("both full valid", 64'(ifmaps_valid), 64'd1);
        @(posedge clk);
        #1 rmode = 1;
        @(posedge clk);
        #1 rmode = 0;
        @(negedge clk);
        check("tready after drain", 64'(S_AXIS_TREADY), 64'd1);
        check("vector1 presented", 64'(ifmaps_valid), 64'd1);
        n = 0;
        while (acc_count < base + 3 * WIN && n < TMO) begin
          @(negedge clk);
          n++;
        end
        if (n >= TMO) timeout_fail("third vector");
        @(posedge clk);
        #1 rmode = 1;
      end
    join
    drain("drain stalled vectors");

    // Random words, gaps, TLAST and consumer readiness.
    @(posedge clk);
    #1 rmode = 2;
    for (int i = 0; i < 200; i++) begin
      send_word($urandom, (i == 199) || ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain("drain random input");

    // Frames of three vectors, sink always ready.
    @(posedge clk);
    #1 tmode = 1;
    frame_vectors = 16'd3;
    for (int v = 0; v < 4; v++) send_psum(rand_vec());
    drain("drain frame test");
    check("tlast count frame3", 64'(tlast_seen), 64'd1);

    // Random backpressure and frame lengths including zero.
    @(posedge clk);
    #1 tmode = 2;
    for (int v = 0; v < 8; v++) begin
      frame_vectors = FRAME_W'($urandom_range(0, 4));
      send_psum(rand_vec());
    end

    // Every lane negative.
    for (int i = 0; i < MAC_NUM; i++) rv[i*PSUM_W +: PSUM_W] = 5'b10011;
    send_psum(rv);
    drain("drain psum");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
